// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC CPU front end: opcodes, IR field layout,
// fetch FSM encoding and default parameters.
package sisc_pkg;

    localparam int PC_W_DEF        = 16;
    localparam int IR_W_DEF        = 32;
    localparam int RESET_PC_DEF    = 0;
    localparam int TIMEOUT_CYC_DEF = 15;
    localparam int CNT_W           = 8;

    typedef enum logic [3:0] {
        OP_NOOP = 4'd0,
        OP_LOD  = 4'd1,
        OP_STR  = 4'd2,
        OP_SWP  = 4'd3,
        OP_BRA  = 4'd4,
        OP_BRR  = 4'd5,
        OP_BNE  = 4'd6,
        OP_BNR  = 4'd7,
        OP_ALU  = 4'd8,
        OP_HLT  = 4'd15
    } opcode_e;

    // IR field positions: fields are FIELD_W-bit nibbles, imm is the low half-word
    localparam int FIELD_W    = 4;
    localparam int IMM_W      = 16;
    localparam int OPCODE_LSB = 28;
    localparam int MM_LSB     = 24;
    localparam int RD_LSB     = 20;
    localparam int RS_LSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selection: reset, increment, absolute or relative branch.
// Arithmetic wraps modulo 2^PC_W.
module sisc_pc_next
    import sisc_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             pc_rst,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] imm_ext;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        imm_ext = PC_W'(imm);
        pc_next = pc;
        if (pc_rst) begin
            pc_next = PC_W'(RESET_PC);
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_next = pc + PC_W'(1);
            end else if (br_sel) begin
                pc_next = pc + imm_ext;
            end else begin
                pc_next = imm_ext;
            end
        end
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: owns PC and IR, runs the imem req/ready
// handshake with a wait timeout, and decodes IR fields for the control FSM.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int RESET_PC    = RESET_PC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_rst,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    input  logic             ir_load,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [IR_W-1:0]  imem_rdata,
    input  logic             imem_ready,
    output logic [3:0]       opcode,
    output logic [3:0]       mm,
    output logic [3:0]       rd_idx,
    output logic [3:0]       rs_idx,
    output logic [3:0]       rt_idx,
    output logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  pc_out,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             fetch_err
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // PC update runs independently of the fetch FSM
    sisc_pc_next #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .pc       (pc_q),
        .imm      (ir_q[IMM_LSB +: IMM_W]),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .pc_next  (pc_d)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            F_IDLE: begin
                if (ir_load) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                // An abort from the control FSM wins over a same-cycle completion
                if (pc_rst) begin
                    req_d   = 1'b0;
                    state_d = F_IDLE;
                end else if (imem_ready) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = F_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                        ir_d    = '0;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = F_ERR;
                    end
                end
            end
            F_ERR: begin
                if (pc_rst) begin
                    err_d   = 1'b0;
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= F_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            addr_q  <= '0;
            ir_q    <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign fetch_busy = req_q;
    assign imem_addr  = addr_q;
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
    assign pc_out     = pc_q;

    assign opcode = ir_q[OPCODE_LSB +: FIELD_W];
    assign mm     = ir_q[MM_LSB     +: FIELD_W];
    assign rd_idx = ir_q[RD_LSB     +: FIELD_W];
    assign rs_idx = ir_q[RS_LSB     +: FIELD_W];
    assign rt_idx = ir_q[RT_LSB     +: FIELD_W];
    assign imm    = ir_q[IMM_LSB    +: IMM_W];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed scenarios followed by a
// random mix of fetches and PC updates against a behavioural PC/IR/memory model.
module tb_sisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [3:0]  opcode, mm, rd_idx, rs_idx, rt_idx;
    logic [15:0] imm;
    logic [15:0] pc_out;
    logic        fetch_busy, fetch_done, fetch_err;

    always #5 clk = ~clk;

    sisc_fetch_unit dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .opcode     (opcode),
        .mm         (mm),
        .rd_idx     (rd_idx),
        .rs_idx     (rs_idx),
        .rt_idx     (rt_idx),
        .imm        (imm),
        .pc_out     (pc_out),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: program memory, architectural PC, IR and sticky error flag
    logic [31:0] mem [logic [15:0]];
    logic [15:0] pc_m;
    logic [31:0] ir_m;
    logic        err_m;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input bit req, input bit done);
        check({tag, " imem_req"},   32'(imem_req),   32'(req));
        check({tag, " fetch_busy"}, 32'(fetch_busy), 32'(req));
        check({tag, " fetch_done"}, 32'(fetch_done), 32'(done));
        check({tag, " fetch_err"},  32'(fetch_err),  32'(err_m));
        check({tag, " pc_out"},     32'(pc_out),     32'(pc_m));
        check({tag, " opcode"},     32'(opcode),     32'(ir_m[31:28]));
        check({tag, " mm"},         32'(mm),         32'(ir_m[27:24]));
        check({tag, " rd_idx"},     32'(rd_idx),     32'(ir_m[23:20]));
        check({tag, " rs_idx"},     32'(rs_idx),     32'(ir_m[19:16]));
        check({tag, " rt_idx"},     32'(rt_idx),     32'(ir_m[15:12]));
        check({tag, " imm"},        32'(imm),        32'(ir_m[15:0]));
    endtask

    // Full fetch at the model PC with 'waits' not-ready cycles; optionally
    // increments PC alongside ir_load and pokes ir_load during the wait.
    task automatic fetch(input int waits, input bit inc, input bit spurious);
        logic [15:0] a;
        a        = pc_m;
        ir_load  = 1'b1;
        pc_write = inc;
        pc_sel   = 1'b0;
        tick();
        if (inc) pc_m = pc_m + 16'd1;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        check_state("fetch.issue", 1'b1, 1'b0);
        check("fetch.issue addr", 32'(imem_addr), 32'(a));
        for (int i = 0; i < waits; i++) begin
            ir_load = spurious;
            tick();
            ir_load = 1'b0;
            check_state("fetch.wait", 1'b1, 1'b0);
            check("fetch.wait addr", 32'(imem_addr), 32'(a));
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        ir_m       = mem_word(a);
        check_state("fetch.done", 1'b0, 1'b1);
        tick();
        check_state("fetch.after", 1'b0, 1'b0);
    endtask

    task automatic pc_update(input bit sel, input bit rel);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_sel   = rel;
        tick();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        if (!sel)     pc_m = pc_m + 16'd1;
        else if (rel) pc_m = pc_m + ir_m[15:0];
        else          pc_m = ir_m[15:0];
        check_state(sel ? (rel ? "br.rel" : "br.abs") : "pc.inc", 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_f      = 1'b0;
        pc_rst     = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        ir_load    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        pc_m       = 16'h0000;
        ir_m       = 32'h0;
        err_m      = 1'b0;

        // 1. Reset, then zero-wait fetch with PC increment on the same cycle
        #12;
        check_state("reset", 1'b0, 1'b0);
        check("reset addr", 32'(imem_addr), 32'h0);
        rst_f = 1'b1;
        tick();
        mem[16'h0000] = 32'h8120_3000;
        fetch(0, 1'b1, 1'b0);
        check("t1 opcode", 32'(opcode), 32'h8);
        check("t1 mm",     32'(mm),     32'h1);
        check("t1 rd_idx", 32'(rd_idx), 32'h2);
        check("t1 rs_idx", 32'(rs_idx), 32'h0);
        check("t1 rt_idx", 32'(rt_idx), 32'h3);
        check("t1 pc",     32'(pc_out), 32'h1);

        // 2. Three wait states with a spurious ir_load during the wait
        mem[16'h0001] = 32'h4000_0010;
        fetch(3, 1'b0, 1'b1);

        // 3. Absolute and relative branches, including 16-bit wrap
        pc_update(1'b1, 1'b0);
        check("t3 pc 0x10", 32'(pc_out), 32'h10);
        mem[16'h0010] = 32'h4000_0040;
        fetch(0, 1'b0, 1'b0);
        pc_update(1'b1, 1'b0);
        check("t3 pc 0x40", 32'(pc_out), 32'h40);
        mem[16'h0040] = 32'h5000_FFF0;
        fetch(1, 1'b0, 1'b0);
        pc_update(1'b1, 1'b1);
        check("t3 pc 0x30", 32'(pc_out), 32'h30);
        mem[16'h0030] = 32'h4000_FFFE;
        fetch(0, 1'b0, 1'b0);
        pc_update(1'b1, 1'b0);
        mem[16'hFFFE] = 32'h5000_0005;
        fetch(2, 1'b0, 1'b0);
        pc_update(1'b1, 1'b1);
        check("t3 pc wrap", 32'(pc_out), 32'h3);

        // 4. Timeout: ready never comes; error is sticky until pc_rst
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check_state("to.issue", 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) begin
            tick();
            check_state("to.wait", 1'b1, 1'b0);
        end
        tick();
        ir_m  = 32'h0;
        err_m = 1'b1;
        check_state("to.err", 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ir_load    = 1'b1;
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            tick();
            check_state("to.ignore", 1'b0, 1'b0);
        end
        ir_load    = 1'b0;
        imem_ready = 1'b0;
        pc_update(1'b0, 1'b0);
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        pc_m   = 16'h0000;
        err_m  = 1'b0;
        check_state("to.clear", 1'b0, 1'b0);
        fetch(1, 1'b1, 1'b0);

        // 5. Abort a pending fetch with pc_rst; a late ready is ignored
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        tick();
        check_state("abort.wait", 1'b1, 1'b0);
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        pc_m   = 16'h0000;
        check_state("abort", 1'b0, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = ~ir_m;
        tick();
        imem_ready = 1'b0;
        check_state("abort.late", 1'b0, 1'b0);
        fetch(0, 1'b0, 1'b0);

        // 6. Asynchronous reset between edges while a fetch is pending
        pc_update(1'b0, 1'b0);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        #2;
        rst_f = 1'b0;
        #1;
        pc_m = 16'h0000;
        ir_m = 32'h0;
        check_state("arst", 1'b0, 1'b0);
        check("arst addr", 32'(imem_addr), 32'h0);
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        rst_f = 1'b1;
        tick();
        imem_ready = 1'b0;
        check_state("arst.late", 1'b0, 1'b0);

        // Random mix of fetches and PC updates against the model
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    fetch(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
                2:       pc_update(1'b1, 1'b0);
                3:       pc_update(1'b1, 1'b1);
                default: pc_update(1'b0, 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
